// File: rtl/life_pkg.sv
// Shared types, geometry helpers and the life rule for the generation updater.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package life_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        CALC  = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Default board geometry; instances override through module parameters.
    localparam int DEF_LINE_WIDTH = 8;
    localparam int DEF_BOARD_W    = 64;
    localparam int DEF_BOARD_H    = 48;

    // Words per board row, and words per bank (one full board image).
    localparam int WPR        = DEF_BOARD_W / DEF_LINE_WIDTH;
    localparam int BANK_WORDS = WPR * DEF_BOARD_H;

    // Each output word costs 10 READ cycles (9 issues + 1 trailing capture),
    // one CALC and one WRITE.
    localparam int CYCLES_PER_WORD = 12;
    localparam int READS_PER_WORD  = 9;

    function automatic int words_per_row(input int board_w, input int line_width);
        return board_w / line_width;
    endfunction

    // Survive on 2 or 3 live neighbours, birth on exactly 3.
    function automatic logic life_rule(input logic alive, input logic [3:0] nbrs);
        return alive ? ((nbrs == 4'd2) || (nbrs == 4'd3)) : (nbrs == 4'd3);
    endfunction

endpackage

// File: rtl/life_word_calc.sv
// Next-state word from a 3-row window (each row: left-edge cell, word, right-edge cell).
// Latency: combinational.
// Backpressure: none; the caller registers the result when it needs it.
module life_word_calc
    import life_pkg::*;
#(
    parameter int LINE_WIDTH = 8
) (
    input  logic [LINE_WIDTH+1:0] row_top,
    input  logic [LINE_WIDTH+1:0] row_mid,
    input  logic [LINE_WIDTH+1:0] row_bot,
    output logic [LINE_WIDTH-1:0] next_word
);

    // Word bit i sits at window index i+1; its neighbours span indices i..i+2.
    always_comb begin
        logic [3:0] cnt;
        cnt       = '0;
        next_word = '0;
        for (int i = 0; i < LINE_WIDTH; i++) begin
            cnt = 4'(row_top[i]) + 4'(row_top[i+1]) + 4'(row_top[i+2])
                + 4'(row_mid[i])                    + 4'(row_mid[i+2])
                + 4'(row_bot[i]) + 4'(row_bot[i+1]) + 4'(row_bot[i+2]);
            next_word[i] = life_rule(row_mid[i+1], cnt);
        end
    end

endmodule

// File: rtl/life_updater.sv
// Computes one game-of-life generation from the front bank into the back bank, then swaps.
// Latency: 12 cycles per word; done_out 12*BANK_WORDS+1 cycles after start_in.
// Backpressure: none; start_in is ignored while busy, memory must answer in 1 cycle. Macro LIFE_TORUS_WRAP_EN selects a toroidal board.
module life_updater
    import life_pkg::*;
#(
    parameter int ADDR_SIZE  = 32,
    parameter int LINE_WIDTH = 8,
    parameter int BOARD_W    = 64,
    parameter int BOARD_H    = 48
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  start_in,
    output logic [ADDR_SIZE-1:0]  addr_r_out,
    input  logic [LINE_WIDTH-1:0] data_in,
    output logic [ADDR_SIZE-1:0]  addr_w_out,
    output logic [LINE_WIDTH-1:0] data_w_out,
    output logic                  we_out,
    output logic                  busy_out,
    output logic                  done_out,
    output logic                  bank_out,
    output logic [15:0]           gen_count_out
);

    localparam int ROW_WORDS = words_per_row(BOARD_W, LINE_WIDTH);
    localparam int BANK_SIZE = ROW_WORDS * BOARD_H;
    localparam int RW        = $clog2(BOARD_H);
    localparam int CW        = (ROW_WORDS > 1) ? $clog2(ROW_WORDS) : 1;

    localparam logic [3:0] K_LAST_ISSUE = 4'(READS_PER_WORD - 1);
    localparam logic [3:0] K_LAST       = 4'(CYCLES_PER_WORD - 3);

    state_t                state_q;
    state_t                state_d;
    logic [RW-1:0]         row_q;
    logic [CW-1:0]         col_q;
    logic [3:0]            k_q;
    logic [LINE_WIDTH-1:0] win_q [9];
    logic                  off_q;
    logic [ADDR_SIZE-1:0]  addr_r_q;
    logic                  last_word;
    logic                  last_col;

    int                    nr;
    int                    nc;
    logic                  rd_off;
    logic [ADDR_SIZE-1:0]  rd_addr;
    logic [ADDR_SIZE-1:0]  wr_addr;
    logic [LINE_WIDTH-1:0] calc_word;

    assign last_col  = (int'(col_q) == ROW_WORDS - 1);
    assign last_word = last_col && (int'(row_q) == BOARD_H - 1);

    // Neighbour word for read k: resolve off-board coordinates, form bank addresses.
    always_comb begin
        nr     = int'(row_q) + int'(k_q) / 3 - 1;
        nc     = int'(col_q) + int'(k_q) % 3 - 1;
        rd_off = 1'b0;
`ifdef LIFE_TORUS_WRAP_EN
        if (nr < 0)              nr = BOARD_H - 1;
        else if (nr >= BOARD_H)  nr = 0;
        if (nc < 0)              nc = ROW_WORDS - 1;
        else if (nc >= ROW_WORDS) nc = 0;
`else
        // Off-board words still get a (clamped) read so every word takes 12 cycles.
        if (nr < 0) begin
            nr     = 0;
            rd_off = 1'b1;
        end else if (nr >= BOARD_H) begin
            nr     = BOARD_H - 1;
            rd_off = 1'b1;
        end
        if (nc < 0) begin
            nc     = 0;
            rd_off = 1'b1;
        end else if (nc >= ROW_WORDS) begin
            nc     = ROW_WORDS - 1;
            rd_off = 1'b1;
        end
`endif
        rd_addr = ADDR_SIZE'((bank_out ? BANK_SIZE : 0) + nr * ROW_WORDS + nc);
        wr_addr = ADDR_SIZE'((bank_out ? 0 : BANK_SIZE)
                             + int'(row_q) * ROW_WORDS + int'(col_q));
    end

    life_word_calc #(
        .LINE_WIDTH (LINE_WIDTH)
    ) u_calc (
        .row_top   ({win_q[0][0], win_q[1], win_q[2][LINE_WIDTH-1]}),
        .row_mid   ({win_q[3][0], win_q[4], win_q[5][LINE_WIDTH-1]}),
        .row_bot   ({win_q[6][0], win_q[7], win_q[8][LINE_WIDTH-1]}),
        .next_word (calc_word)
    );

    // State register.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) state_q <= IDLE;
        else           state_q <= state_d;
    end

    // Next-state logic; start_in only matters in IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_in) state_d = READ;
            READ:    if (k_q == K_LAST) state_d = CALC;
            CALC:    state_d = WRITE;
            WRITE:   state_d = last_word ? DONE : READ;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode; the read address shows the live issue and otherwise holds the last one.
    always_comb begin
        busy_out   = (state_q != IDLE);
        done_out   = (state_q == DONE);
        we_out     = (state_q == WRITE);
        addr_r_out = ((state_q == READ) && (k_q <= K_LAST_ISSUE)) ? rd_addr : addr_r_q;
    end

    // Sweep position, read window capture, write word/address and bank bookkeeping.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            row_q         <= '0;
            col_q         <= '0;
            k_q           <= '0;
            off_q         <= 1'b0;
            addr_r_q      <= '0;
            addr_w_out    <= '0;
            data_w_out    <= '0;
            bank_out      <= 1'b0;
            gen_count_out <= '0;
            for (int i = 0; i < 9; i++) win_q[i] <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_in) begin
                        row_q <= '0;
                        col_q <= '0;
                        k_q   <= '0;
                    end
                end
                READ: begin
                    if (k_q <= K_LAST_ISSUE) begin
                        addr_r_q <= rd_addr;
                        off_q    <= rd_off;
                    end
                    if (k_q != 4'd0) win_q[k_q - 4'd1] <= off_q ? '0 : data_in;
                    k_q <= k_q + 4'd1;
                end
                CALC: begin
                    data_w_out <= calc_word;
                    addr_w_out <= wr_addr;
                end
                WRITE: begin
                    k_q <= '0;
                    if (!last_word) begin
                        if (last_col) begin
                            col_q <= '0;
                            row_q <= row_q + RW'(1);
                        end else begin
                            col_q <= col_q + CW'(1);
                        end
                    end
                end
                DONE: begin
                    bank_out      <= ~bank_out;
                    gen_count_out <= gen_count_out + 16'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_life_updater.sv
// Directed bench for life_updater on a 16x4 board with a 1-cycle-latency memory model.
// Latency: n/a.
// Backpressure: n/a.
module tb_life_updater;

    localparam int AS = 32;

    // Board images: 8 words, word 0 (row 0, col 0) in the top byte.
    localparam logic [63:0] IMG_ZERO  = 64'h0000_0000_0000_0000;
    localparam logic [63:0] IMG_HBLK  = 64'h0000_1C00_0000_0000; // row 1, x=3..5
    localparam logic [63:0] IMG_VBLK  = 64'h0800_0800_0800_0000; // x=4, rows 0..2
    localparam logic [63:0] IMG_WB_H  = 64'h0000_01C0_0000_0000; // row 1, x=7..9
    localparam logic [63:0] IMG_WB_V  = 64'h0080_0080_0080_0000; // x=8, rows 0..2
    localparam logic [63:0] IMG_BLOCK = 64'hC000_C000_0000_0000; // x=0..1, rows 0..1
    localparam logic [63:0] IMG_BLKX  = 64'hC001_C000_0000_0000; // block plus x=15 row 0

    logic           clk = 1'b0;
    logic           rst_n;
    logic           start;
    logic [AS-1:0]  addr_r;
    logic [AS-1:0]  addr_w;
    logic [7:0]     data_in;
    logic [7:0]     data_w;
    logic           we;
    logic           busy;
    logic           done;
    logic           bank;
    logic [15:0]    gen;

    logic [7:0]     mem [16];
    logic           ld_en;
    logic [3:0]     ld_a;
    logic [7:0]     ld_d;
    int             front_wr_err = 0;
    int             back_rd_err  = 0;

    int             checks = 0;
    int             errors = 0;
    logic           exp_bank;
    logic [15:0]    exp_gen;

    always #5 clk = ~clk;

    life_updater #(
        .ADDR_SIZE  (AS),
        .LINE_WIDTH (8),
        .BOARD_W    (16),
        .BOARD_H    (4)
    ) dut (
        .clk_in        (clk),
        .rst_n_in      (rst_n),
        .start_in      (start),
        .addr_r_out    (addr_r),
        .data_in       (data_in),
        .addr_w_out    (addr_w),
        .data_w_out    (data_w),
        .we_out        (we),
        .busy_out      (busy),
        .done_out      (done),
        .bank_out      (bank),
        .gen_count_out (gen)
    );

    // Memory model plus bank-discipline monitors.
    always @(posedge clk) begin
        data_in <= mem[addr_r[3:0]];
        if (we)         mem[addr_w[3:0]] <= data_w;
        else if (ld_en) mem[ld_a] <= ld_d;
        if (we && ((addr_w >= 16) || (addr_w[3] == bank))) front_wr_err <= front_wr_err + 1;
        if (busy && ((addr_r >= 16) || (addr_r[3] != bank))) back_rd_err <= back_rd_err + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic wr_word(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        ld_en = 1'b1;
        ld_a  = a;
        ld_d  = d;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic load_bank(input logic b, input logic [63:0] img);
        for (int i = 0; i < 8; i++) wr_word({b, 3'(i)}, img[63-8*i -: 8]);
    endtask

    function automatic logic [63:0] read_bank(input logic b);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) r[63-8*i -: 8] = mem[{b, 3'(i)}];
        return r;
    endfunction

    // Cell-level reference: cell (x,y) is bit 63-(16y+x).
    function automatic logic [63:0] golden(input logic [63:0] img);
        logic [63:0] r;
        int n, xx, yy;
        logic alive;
        r = '0;
        for (int y = 0; y < 4; y++) begin
            for (int x = 0; x < 16; x++) begin
                n = 0;
                for (int dy = -1; dy <= 1; dy++) begin
                    for (int dx = -1; dx <= 1; dx++) begin
                        yy = y + dy;
                        xx = x + dx;
`ifdef LIFE_TORUS_WRAP_EN
                        yy = (yy + 4) % 4;
                        xx = (xx + 16) % 16;
`endif
                        if (!(dx == 0 && dy == 0) && yy >= 0 && yy < 4 && xx >= 0 && xx < 16)
                            n += int'(img[63 - (yy*16 + xx)]);
                    end
                end
                alive = img[63 - (y*16 + x)];
                r[63 - (y*16 + x)] = alive ? (n == 2 || n == 3) : (n == 3);
            end
        end
        return r;
    endfunction

    // One start pulse; returns start-to-done cycles (0 on timeout) and write-port stats.
    task automatic run_gen(output int lat, output int wcnt, output int wbad, output int idle_cyc);
        int base;
        base     = exp_bank ? 0 : 8;
        lat      = 0;
        wcnt     = 0;
        wbad     = 0;
        idle_cyc = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= 2000; c++) begin
            if (!busy) idle_cyc++;
            if (we) begin
                if (addr_w !== 32'(base + wcnt)) wbad++;
                wcnt++;
            end
            if (done) begin
                lat = c;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
    endtask

    task automatic do_gen(input string tag, input logic [63:0] src, input logic [63:0] expd);
        int lat, wcnt, wbad, idle_cyc;
        run_gen(lat, wcnt, wbad, idle_cyc);
        chk({tag, "_latency"}, 64'(lat), 64'd97);
        chk({tag, "_we_count"}, 64'(wcnt), 64'd8);
        chk({tag, "_we_addr_order"}, 64'(wbad), 64'd0);
        chk({tag, "_busy_gaps"}, 64'(idle_cyc), 64'd0);
        exp_bank = ~exp_bank;
        exp_gen  = exp_gen + 16'd1;
        chk({tag, "_bank"}, 64'(bank), 64'(exp_bank));
        chk({tag, "_gen_count"}, 64'(gen), 64'(exp_gen));
        chk({tag, "_idle_busy"}, 64'(busy), 64'd0);
        chk({tag, "_new_front"}, read_bank(exp_bank), expd);
        chk({tag, "_old_front"}, read_bank(~exp_bank), src);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_we"}, 64'(we), 64'd0);
        chk({tag, "_bank"}, 64'(bank), 64'd0);
        chk({tag, "_gen"}, 64'(gen), 64'd0);
        chk({tag, "_addr_r"}, 64'(addr_r), 64'd0);
        chk({tag, "_addr_w"}, 64'(addr_w), 64'd0);
        chk({tag, "_data_w"}, 64'(data_w), 64'd0);
    endtask

    initial begin
        int ndone;
        logic [15:0] gen_before;
        rst_n    = 1'b0;
        start    = 1'b0;
        ld_en    = 1'b0;
        ld_a     = '0;
        ld_d     = '0;
        exp_bank = 1'b0;
        exp_gen  = '0;

        repeat (3) @(negedge clk);
        chk_outputs_zero("reset");
        rst_n = 1'b1;

        // Blinker: timing, write addresses 8..15, then back to the original in bank 0.
        load_bank(1'b0, IMG_HBLK);
        load_bank(1'b1, IMG_ZERO);
        do_gen("blink1", IMG_HBLK, IMG_VBLK);
        do_gen("blink2", IMG_VBLK, IMG_HBLK);

        // Blinker straddling the word boundary at x=7/8.
        load_bank(exp_bank, IMG_WB_H);
        do_gen("wblink", IMG_WB_H, IMG_WB_V);

        // Still-life block, then block plus an edge cell that only interacts on a torus.
        load_bank(exp_bank, IMG_BLOCK);
        do_gen("block", IMG_BLOCK, IMG_BLOCK);
        load_bank(exp_bank, IMG_BLKX);
        do_gen("blkwrap", IMG_BLKX, golden(IMG_BLKX));

        // Extra start pulses at cycle 40 and in the DONE cycle are ignored.
        load_bank(exp_bank, IMG_HBLK);
        gen_before = gen;
        ndone = 0;
        @(negedge clk);
        start = 1'b1;
        for (int c = 1; c <= 250; c++) begin
            @(negedge clk);
            start = (c == 40) || done;
            if (done) ndone++;
        end
        start = 1'b0;
        @(negedge clk);
        exp_bank = ~exp_bank;
        exp_gen  = exp_gen + 16'd1;
        chk("busy_start_done_count", 64'(ndone), 64'd1);
        chk("busy_start_gen_count", 64'(gen), 64'(gen_before + 16'd1));
        chk("busy_start_bank", 64'(bank), 64'(exp_bank));
        chk("busy_start_idle", 64'(busy), 64'd0);
        chk("busy_start_result", read_bank(exp_bank), IMG_VBLK);

        // Reset at cycle 50 of a generation; front bank 0 must survive untouched.
        load_bank(exp_bank, IMG_HBLK);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (49) @(negedge clk);
        chk("midrst_busy_before", 64'(busy), 64'd1);
        #2 rst_n = 1'b0;
        #1 chk_outputs_zero("midrst");
        chk("midrst_front_intact", read_bank(1'b0), IMG_HBLK);
        @(negedge clk);
        rst_n    = 1'b1;
        exp_bank = 1'b0;
        exp_gen  = '0;
        do_gen("post_rst", IMG_HBLK, IMG_VBLK);

        chk("front_bank_writes", 64'(front_wr_err), 64'd0);
        chk("back_bank_reads", 64'(back_rd_err), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
